// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback with a memory-wait watchdog.
// Define RISCV_ILLEGAL_TRAP_EN to trap on unrecognised opcodes instead of executing them as NOPs.
module riscv_multicycle_ctrl #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] instr_i,
  input  logic [2:0]      flags_i,
  input  logic            mem_ready_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            ir_we_o,
  output logic            pc_we_o,
  output logic            reg_write_o,
  output logic [1:0]      pc_src_o,
  output logic            alu_src_o,
  output logic [4:0]      alu_ctrl_o,
  output logic [2:0]      imm_src_o,
  output logic [1:0]      result_src_o,
  output logic [2:0]      state_o,
  output logic            timeout_o,
  output logic            illegal_o
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StHalt      = 3'd5,
    StTrap      = 3'd6
  } state_e;

  localparam logic [6:0] OpLoad   = 7'd3;
  localparam logic [6:0] OpStore  = 7'd35;
  localparam logic [6:0] OpBranch = 7'd99;
  localparam logic [6:0] OpImm    = 7'd19;
  localparam logic [6:0] OpReg    = 7'd51;
  localparam logic [6:0] OpAuipc  = 7'd23;
  localparam logic [6:0] OpLui    = 7'd55;
  localparam logic [6:0] OpJalr   = 7'd103;
  localparam logic [6:0] OpJal    = 7'd111;

  localparam logic [XLEN-1:0] IrNop = XLEN'(32'h0000_0013);

  localparam int unsigned     CntW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam bit              WdogEn   = (TIMEOUT_CYCLES != 0);

  state_e          state_q, state_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [CntW-1:0] wait_q, wait_d, wait_inc;
  logic            timeout_q, timeout_d;
  logic            wait_expire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       is_load, is_store, is_branch, is_jal, is_jalr, op_legal, br_taken;
  logic       unused_ir;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign funct7_b5 = ir_q[30];
  assign unused_ir = ^{ir_q[XLEN-1:31], ir_q[29:15], ir_q[11:7]};

  assign is_load   = (opcode == OpLoad);
  assign is_store  = (opcode == OpStore);
  assign is_branch = (opcode == OpBranch);
  assign is_jal    = (opcode == OpJal);
  assign is_jalr   = (opcode == OpJalr);
  assign op_legal  = is_load | is_store | is_branch | is_jal | is_jalr | (opcode == OpImm) |
                     (opcode == OpReg) | (opcode == OpAuipc) | (opcode == OpLui);

  assign wait_inc    = (wait_q == '1) ? wait_q : wait_q + CntW'(1);
  assign wait_expire = WdogEn && !mem_ready_i && (wait_q == WaitLast);

  // flags_i = {zero, gt, gtu}
  always_comb begin
    case (funct3)
      3'd0:    br_taken = flags_i[2];
      3'd1:    br_taken = ~flags_i[2];
      3'd4:    br_taken = ~flags_i[1];
      3'd5:    br_taken = flags_i[1];
      3'd6:    br_taken = ~flags_i[0];
      3'd7:    br_taken = flags_i[0];
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctrl_o   = 5'd0;
    imm_src_o    = 3'd0;
    alu_src_o    = 1'b1;
    result_src_o = 2'd0;
    case (opcode)
      OpReg: begin
        alu_src_o = 1'b0;
        case (funct3)
          3'd0:    alu_ctrl_o = funct7_b5 ? 5'd1 : 5'd0;
          3'd1:    alu_ctrl_o = 5'd2;
          3'd2:    alu_ctrl_o = 5'd4;
          3'd3:    alu_ctrl_o = 5'd5;
          3'd4:    alu_ctrl_o = 5'd6;
          3'd5:    alu_ctrl_o = funct7_b5 ? 5'd8 : 5'd7;
          3'd6:    alu_ctrl_o = 5'd11;
          default: alu_ctrl_o = 5'd12;
        endcase
      end
      OpImm: begin
        case (funct3)
          3'd0:    alu_ctrl_o = 5'd0;
          3'd1:    alu_ctrl_o = 5'd3;
          3'd2:    alu_ctrl_o = 5'd4;
          3'd3:    alu_ctrl_o = 5'd5;
          3'd4:    alu_ctrl_o = 5'd6;
          3'd5:    alu_ctrl_o = funct7_b5 ? 5'd10 : 5'd9;
          3'd6:    alu_ctrl_o = 5'd11;
          default: alu_ctrl_o = 5'd12;
        endcase
      end
      OpLoad:   result_src_o = 2'd1;
      OpStore:  imm_src_o = 3'd1;
      OpBranch: begin
        imm_src_o  = 3'd2;
        alu_ctrl_o = 5'd1;
        alu_src_o  = 1'b0;
      end
      OpJal: begin
        imm_src_o    = 3'd3;
        result_src_o = 2'd2;
      end
      OpJalr:   result_src_o = 2'd2;
      OpLui: begin
        imm_src_o  = 3'd4;
        alu_ctrl_o = 5'd13;
      end
      OpAuipc: begin
        imm_src_o    = 3'd4;
        alu_ctrl_o   = 5'd13;
        result_src_o = 2'd3;
      end
      default: ;
    endcase
  end

`ifdef RISCV_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

  // Wait counter defaults to 0, which covers entry into FETCH/MEMORY and every mem_ready_i.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = '0;
    timeout_d = timeout_q;
`ifdef RISCV_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    unique case (state_q)
      StFetch: begin
        if (mem_ready_i) begin
          ir_d    = instr_i;
          state_d = StDecode;
        end else if (wait_expire) begin
          timeout_d = 1'b1;
          state_d   = StHalt;
        end else begin
          wait_d = wait_inc;
        end
      end
      StDecode: begin
        state_d = StExecute;
`ifdef RISCV_ILLEGAL_TRAP_EN
        if (!op_legal) begin
          illegal_d = 1'b1;
          state_d   = StTrap;
        end
`endif
      end
      StExecute: begin
        if (is_load || is_store)        state_d = StMemory;
        else if (is_branch || !op_legal) state_d = StFetch;
        else                             state_d = StWriteback;
      end
      StMemory: begin
        if (mem_ready_i) begin
          state_d = is_store ? StFetch : StWriteback;
        end else if (wait_expire) begin
          timeout_d = 1'b1;
          state_d   = StHalt;
        end else begin
          wait_d = wait_inc;
        end
      end
      StWriteback: state_d = StFetch;
      default:     state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StFetch;
      ir_q      <= IrNop;
      wait_q    <= '0;
      timeout_q <= 1'b0;
`ifdef RISCV_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
`ifdef RISCV_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  logic       mem_req, mem_we, ir_we, pc_we, reg_write;
  logic [1:0] pc_src;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_write = 1'b0;
    pc_src    = 2'd0;
    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        ir_we   = mem_ready_i;
      end
      StExecute: begin
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_src = br_taken ? 2'd1 : 2'd0;
        end else if (!op_legal) begin
          pc_we = 1'b1;
        end
      end
      StMemory: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        pc_we   = is_store & mem_ready_i;
      end
      StWriteback: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
        pc_src    = is_jalr ? 2'd2 : (is_jal ? 2'd1 : 2'd0);
      end
      default: ;
    endcase
  end

  // Reset gates the request/strobes combinationally so they drop without waiting for a clock.
  assign mem_req_o   = mem_req & rst_ni;
  assign mem_we_o    = mem_we & rst_ni;
  assign ir_we_o     = ir_we & rst_ni;
  assign pc_we_o     = pc_we & rst_ni;
  assign reg_write_o = reg_write & rst_ni;
  assign pc_src_o    = pc_src;
  assign state_o     = state_q;
  assign timeout_o   = timeout_q;

endmodule

// File: doc/riscv_multicycle_ctrl.md
RISCV_MULTICYCLE_CTRL -- requirements
Module: riscv_multicycle_ctrl

Interface
REQ-001 SHALL have parameter XLEN, 32, instruction/IR width (only 32 legal).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 64, maximum memory wait cycles; 0 disables the watchdog.
REQ-003 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port instr_i  in  XLEN  fetched instruction, valid when mem_ready_i=1 in FETCH.
REQ-006 SHALL have port flags_i  in  3  {zero, gt (rs1>=rs2 signed), gtu (rs1>=rs2 unsigned)}.
REQ-007 SHALL have port mem_ready_i  in  1  memory completes current request.
REQ-008 SHALL have ports mem_req_o out 1, mem_we_o out 1: memory request and write-enable.
REQ-009 SHALL have ports ir_we_o out 1, pc_we_o out 1, reg_write_o out 1: IR/PC/register-file write strobes.
REQ-010 SHALL have ports pc_src_o out 2 (0 PC+4, 1 PC+imm, 2 rs1+imm), alu_src_o out 1 (0 rs2, 1 imm).
REQ-011 SHALL have ports alu_ctrl_o out 5, imm_src_o out 3 (0 I,1 S,2 B,3 J,4 U), result_src_o out 2 (0 ALU,1 mem,2 PC+4,3 PC+imm).
REQ-012 SHALL have ports state_o out 3 (current state code), timeout_o out 1 (sticky watchdog flag), illegal_o out 1.

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5, TRAP=6.
REQ-014 FETCH SHALL drive mem_req_o=1, mem_we_o=0; on mem_ready_i=1 pulse ir_we_o for one cycle, latch instr_i into internal IR, go DECODE; otherwise stay.
REQ-015 DECODE SHALL last exactly one cycle and always go EXECUTE; all decode outputs derive from IR, never from instr_i.
REQ-016 alu_ctrl_o SHALL encode 0 ADD,1 SUB,2 SLL,3 SLLI,4 SLT,5 SLTU,6 XOR,7 SRL,8 SRA,9 SRLI,10 SRAI,11 OR,12 AND,13 U-pass; loads/stores/JAL/JALR use 0, branches use 1.
REQ-017 EXECUTE branch (op 99) SHALL sample flags_i: beq zero, bne ~zero, blt ~gt, bge gt, bltu ~gtu, bgeu gtu; assert pc_we_o with pc_src_o=1 if taken else 0; go FETCH; funct3 2/3 SHALL be not-taken.
REQ-018 EXECUTE load/store (op 3/35) SHALL go MEMORY; all other legal ops (19,51,23,55,103,111) SHALL go WRITEBACK.
REQ-019 MEMORY SHALL drive mem_req_o=1, mem_we_o=1 for stores only; on mem_ready_i: store asserts pc_we_o (pc_src 0) and goes FETCH, load goes WRITEBACK.
REQ-020 WRITEBACK SHALL assert reg_write_o and pc_we_o for one cycle (pc_src 2 for JALR, 1 for JAL, else 0; result_src 1 load, 2 JAL/JALR, 3 AUIPC, else 0), then go FETCH.
REQ-021 reg_write_o, pc_we_o, ir_we_o, mem_we_o SHALL be 0 in every state/condition not listed above.
REQ-022 Wait counter SHALL reset to 0 on entry to FETCH/MEMORY and on each mem_ready_i, increment each waiting cycle, saturate.
REQ-023 With TIMEOUT_CYCLES>0, a wait reaching TIMEOUT_CYCLES cycles without mem_ready_i SHALL set timeout_o and go HALT; mem_ready_i in that same cycle SHALL win.
REQ-024 HALT SHALL drive all strobes and mem_req_o to 0 and be exited only by reset.
REQ-025 Latency: ALU op with zero-wait memory = 4 cycles FETCH-to-FETCH; load 5; store 4; branch 3.

Reset
REQ-026 rst_ni low SHALL immediately force state FETCH, IR=0x00000013, wait counter 0, timeout_o 0, illegal_o 0, all strobes 0, mem_req_o 0, independent of clk_i.
REQ-027 Reset asserted mid-MEMORY SHALL drop mem_req_o/mem_we_o asynchronously; first cycle after release SHALL be FETCH with mem_req_o=1.

Configuration
REQ-028 Macro RISCV_ILLEGAL_TRAP_EN defined: unrecognised opcode in DECODE SHALL go TRAP, set illegal_o sticky, hold strobes 0; exit only by reset.
REQ-029 Macro undefined: unrecognised opcode SHALL execute as NOP (pc_we_o, pc_src 0 in EXECUTE, back to FETCH) and illegal_o SHALL be tied 0.

Verification
REQ-030 Reset, fetch addi (0x00500093), ready immediate -> states 0,1,2,4,0; WRITEBACK reg_write_o=1, alu_ctrl_o=0, alu_src_o=1.
REQ-031 lw with mem_ready_i delayed 3 cycles in MEMORY -> mem_req_o high 4 cycles, then WRITEBACK result_src_o=1, reg_write_o=1.
REQ-032 bne with flags_i=3'b000 -> EXECUTE pc_we_o=1, pc_src_o=1; with flags_i=3'b100 -> pc_src_o=0; reg_write_o never 1.
REQ-033 TIMEOUT_CYCLES=4, mem_ready_i held 0 in FETCH -> timeout_o=1, state_o=5 after 4 wait cycles; stays until rst_ni low.
REQ-034 Opcode 0x7F with RISCV_ILLEGAL_TRAP_EN -> state_o=6, illegal_o=1; without macro -> pc_we_o pulse, back to FETCH.
REQ-035 rst_ni pulsed low during MEMORY of sw -> mem_we_o falls same cycle, next state FETCH, IR reads as NOP.
